// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller.
// Generates a one-cycle clock-enable pulse for a CPU pipeline in one of three
// modes: HALT (no pulses), RUN (one pulse every div_q clkin cycles) and STEP
// (one pulse per debounced press of a bouncing push-button). A free-running
// counter reports how many enable pulses have been issued since reset.
module cpu_clk_ctrl #(
  parameter int DIV_W      = 28,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             step_btn,
  output logic             cpu_ce,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] ce_count
);

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  // Wide enough to hold the value DEB_CYCLES itself.
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       state_q,    state_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [DIV_W-1:0] phase_q,    phase_d;
  logic             cpu_ce_q,   cpu_ce_d;
  logic [CNT_W-1:0] ce_count_q, ce_count_d;

  logic             sync1_q, sync2_q;
  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q,   deb_cnt_d;
  logic             deb_prev_q;

  logic             run_stay;
  logic             run_entry;
  logic             period_end;
  logic             deb_rise;
  logic             step_fire;
  logic [DIV_W-1:0] div_eff;

  // Next-state decode: the requested mode takes effect on the next edge;
  // the unused encoding 11 falls back to HALT.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    state_d = ST_HALT;
    case (mode)
      2'b01:   state_d = ST_RUN;
      2'b10:   state_d = ST_STEP;
      default: state_d = ST_HALT;
    endcase
  end

  assign run_stay   = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign run_entry  = (state_q != ST_RUN) && (state_d == ST_RUN);
  assign period_end = (phase_q == (div_q - DIV_W'(1)));

  // A divisor of 0 would mean "never"; treat it like 1 (enable every cycle).
  assign div_eff = (div == '0) ? DIV_W'(1) : div;

  // Divisor latch and phase counter. The phase counter only advances while
  // RUN persists; entering or leaving RUN restarts it at 0, so a partial
  // period never produces a pulse.
  always_comb begin
    div_d   = div_q;
    phase_d = '0;
    if (run_entry) begin
      div_d = div_eff;
    end
    if (run_stay) begin
      phase_d = period_end ? '0 : (phase_q + DIV_W'(1));
    end
  end

  // Debounce: the accepted level follows the synchronized button only after
  // it has disagreed for DEB_CYCLES consecutive cycles; any agreement
  // restarts the count. Runs regardless of FSM state.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (sync2_q != deb_level_q) begin
      if ((deb_cnt_q + DEB_W'(1)) == DEB_W'(DEB_CYCLES)) begin
        deb_level_d = sync2_q;
        deb_cnt_d   = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // A debounced rising edge fires only if STEP is both current and next;
  // edges seen in HALT/RUN, or on a STEP->RUN change, are dropped.
  assign deb_rise  = deb_level_q && !deb_prev_q;
  assign step_fire = deb_rise && (state_q == ST_STEP) && (state_d == ST_STEP);

  // Enable pulse and issued-pulse counter (wraps naturally at all-ones).
  always_comb begin
    cpu_ce_d   = (run_stay && period_end) || step_fire;
    ce_count_d = cpu_ce_d ? (ce_count_q + CNT_W'(1)) : ce_count_q;
  end

  // State registers; reset forces everything to its idle value at once.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      div_q       <= DIV_W'(1);
      phase_q     <= '0;
      cpu_ce_q    <= 1'b0;
      ce_count_q  <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      deb_prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the two synchronizer stages really are two stages.
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      cpu_ce_q    <= cpu_ce_d;
      ce_count_q  <= ce_count_d;
      sync1_q     <= step_btn;
      sync2_q     <= sync1_q;
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_prev_q  <= deb_level_q;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign state_o  = state_q;
  assign ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: a vector table for the basic
// RUN/HALT behaviour, then hand-written sequences for the multi-cycle cases.
module tb_cpu_clk_ctrl;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [27:0] div;
  logic        step_btn;
  logic        cpu_ce;
  logic [1:0]  state_o;
  logic [31:0] ce_count;

  // Narrow-counter copy used only to observe counter wrap-around.
  logic        cpu_ce2;
  logic [1:0]  state_o2;
  logic [1:0]  ce_count2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [27:0] div;
    logic        btn;
    logic        exp_ce;
    logic [1:0]  exp_state;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  cpu_clk_ctrl dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .mode     (mode),
    .div      (div),
    .step_btn (step_btn),
    .cpu_ce   (cpu_ce),
    .state_o  (state_o),
    .ce_count (ce_count)
  );

  cpu_clk_ctrl #(.DIV_W(28), .DEB_CYCLES(16), .CNT_W(2)) dut_wrap (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .mode     (mode),
    .div      (div),
    .step_btn (step_btn),
    .cpu_ce   (cpu_ce2),
    .state_o  (state_o2),
    .ce_count (ce_count2)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clkin edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Run n cycles, counting pulses and remembering the first pulse index.
  task automatic run_cycles(input int n, output int pulses, output int first_idx);
    pulses    = 0;
    first_idx = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        if (first_idx < 0) first_idx = i;
        pulses++;
      end
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic [27:0] d, input logic b,
                              input logic ce, input logic [1:0] st, input logic [31:0] cnt);
    vec_t v;
    v.mode = m; v.div = d; v.btn = b;
    v.exp_ce = ce; v.exp_state = st; v.exp_count = cnt;
    return v;
  endfunction

  initial begin
    int exp_cnt;
    int pulses;
    int first_idx;

    // Two idle cycles, then RUN with div=4: pulses at cycles 4,8,..,20.
    vecs.push_back(mk(2'b00, 28'd4, 1'b0, 1'b0, 2'b00, 32'd0));
    vecs.push_back(mk(2'b00, 28'd4, 1'b0, 1'b0, 2'b00, 32'd0));
    for (int k = 0; k <= 20; k++) begin
      vecs.push_back(mk(2'b01, 28'd4, 1'b0, (k > 0) && (k % 4 == 0), 2'b01, 32'(k / 4)));
    end
    vecs.push_back(mk(2'b00, 28'd4, 1'b0, 1'b0, 2'b00, 32'd5));
    // Brief RUN then mode 11: behaves as HALT, no partial-period pulse.
    vecs.push_back(mk(2'b01, 28'd4, 1'b0, 1'b0, 2'b01, 32'd5));
    vecs.push_back(mk(2'b01, 28'd4, 1'b0, 1'b0, 2'b01, 32'd5));
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(2'b11, 28'd4, 1'b0, 1'b0, 2'b00, 32'd5));
    end

    // Reset state.
    rst_n = 1'b0; mode = 2'b00; div = 28'd4; step_btn = 1'b0;
    #2;
    check("reset ce", 32'(cpu_ce), 32'd0);
    check("reset state", 32'(state_o), 32'd0);
    check("reset count", ce_count, 32'd0);
    #20;
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      mode = vecs[i].mode; div = vecs[i].div; step_btn = vecs[i].btn;
      tick();
      check($sformatf("vec%0d ce", i), 32'(cpu_ce), 32'(vecs[i].exp_ce));
      check($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d count", i), ce_count, vecs[i].exp_count);
    end
    exp_cnt = 5;

    // div = 0 and div = 1: enable held high from cycle 1 of RUN.
    for (int d = 0; d < 2; d++) begin
      div = 28'(d); mode = 2'b01;
      tick();
      check($sformatf("div%0d entry ce", d), 32'(cpu_ce), 32'd0);
      for (int c = 1; c <= 5; c++) begin
        tick();
        exp_cnt++;
        check($sformatf("div%0d cyc%0d ce", d, c), 32'(cpu_ce), 32'd1);
      end
      check($sformatf("div%0d count", d), ce_count, 32'(exp_cnt));
      mode = 2'b00;
      tick();
      check($sformatf("div%0d halt ce", d), 32'(cpu_ce), 32'd0);
    end

    // div changed 4 -> 8 mid-RUN: spacing stays 4 until RUN is re-entered.
    div = 28'd4; mode = 2'b01;
    tick();
    div = 28'd8;
    run_cycles(12, pulses, first_idx);
    exp_cnt += 3;
    check("divchg pulses", 32'(pulses), 32'd3);
    check("divchg first", 32'(first_idx), 32'd3);
    mode = 2'b00;
    tick();
    mode = 2'b01;
    tick();
    run_cycles(8, pulses, first_idx);
    exp_cnt += 1;
    check("div8 pulses", 32'(pulses), 32'd1);
    check("div8 first", 32'(first_idx), 32'd7);
    mode = 2'b00;
    tick();

    // HALT mid-period (div=10, 7 cycles), then re-enter: pulse at cycle 10.
    div = 28'd10; mode = 2'b01;
    run_cycles(7, pulses, first_idx);
    mode = 2'b00;
    begin
      int p2, f2;
      run_cycles(15, p2, f2);
      check("midhalt pulses", 32'(pulses + p2), 32'd0);
    end
    mode = 2'b01;
    tick();
    run_cycles(10, pulses, first_idx);
    exp_cnt += 1;
    check("reenter pulses", 32'(pulses), 32'd1);
    check("reenter first", 32'(first_idx), 32'd9);
    check("reenter count", ce_count, 32'(exp_cnt));
    mode = 2'b00;
    tick();

    // STEP: bouncing press gives exactly one pulse.
    mode = 2'b10;
    tick();
    pulses = 0;
    for (int b = 0; b < 5; b++) begin
      int p, f;
      step_btn = (b % 2 == 0);
      run_cycles(3, p, f);
      pulses += p;
    end
    step_btn = 1'b1;
    begin
      int p, f;
      run_cycles(40, p, f);
      pulses += p;
    end
    exp_cnt += 1;
    check("bounce pulses", 32'(pulses), 32'd1);
    check("bounce count", ce_count, 32'(exp_cnt));
    step_btn = 1'b0;
    run_cycles(40, pulses, first_idx);
    check("release pulses", 32'(pulses), 32'd0);
    // Clean press: 2 sync + 16 debounce + 1 cycles to the pulse.
    step_btn = 1'b1;
    run_cycles(40, pulses, first_idx);
    exp_cnt += 1;
    check("press2 pulses", 32'(pulses), 32'd1);
    check("press2 latency", 32'(first_idx), 32'd18);
    check("press2 count", ce_count, 32'(exp_cnt));
    step_btn = 1'b0;
    run_cycles(40, pulses, first_idx);

    // Presses in RUN and HALT are discarded, not queued for STEP.
    div = 28'd200; mode = 2'b01;
    tick();
    step_btn = 1'b1;
    run_cycles(40, pulses, first_idx);
    check("run press pulses", 32'(pulses), 32'd0);
    step_btn = 1'b0;
    run_cycles(40, pulses, first_idx);
    mode = 2'b00; step_btn = 1'b1;
    run_cycles(40, pulses, first_idx);
    check("halt press pulses", 32'(pulses), 32'd0);
    mode = 2'b10;
    run_cycles(20, pulses, first_idx);
    check("no queued pulse", 32'(pulses), 32'd0);
    check("filter count", ce_count, 32'(exp_cnt));
    step_btn = 1'b0;
    run_cycles(40, pulses, first_idx);

    // Asynchronous reset mid-RUN, between clock edges.
    div = 28'd1; mode = 2'b01;
    tick(); tick(); tick();
    exp_cnt += 2;
    check("pre-reset ce", 32'(cpu_ce), 32'd1);
    check("pre-reset count", ce_count, 32'(exp_cnt));
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst ce", 32'(cpu_ce), 32'd0);
    check("async rst count", ce_count, 32'd0);
    check("async rst state", 32'(state_o), 32'd0);
    tick(); tick();
    check("held rst state", 32'(state_o), 32'd0);
    mode = 2'b00;
    rst_n = 1'b1;
    tick();

    // Counter wrap on the 2-bit copy: 3 = all-ones, 4th pulse wraps to 0.
    check("wrap start", 32'(ce_count2), 32'd0);
    mode = 2'b01; div = 28'd1;
    tick();
    tick(); tick(); tick();
    check("wrap all-ones", 32'(ce_count2), 32'd3);
    tick();
    check("wrap to zero", 32'(ce_count2), 32'd0);
    check("wide count", ce_count, 32'd4);
    mode = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
